// File: rtl/channel_accum_7_pkg.sv
// ============================================================================
// Module  : channel_accum_7_pkg
// Purpose : Shared constants and types for the channel accumulator slice.
//           Carries the data width shared with num_data.v (`DATA_LEN) and the
//           accumulator guard width (`ACC_GUARD) reused by other accumulators.
// Ports   : none (package)
// Config  : RELU_EN (used by channel_accum_7_sat_shift) - clamp negatives to 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_LEN
`define DATA_LEN 16
`endif

`ifndef ACC_GUARD
`define ACC_GUARD 4
`endif

package channel_accum_7_pkg;

  localparam int DATA_LEN  = `DATA_LEN;
  localparam int ACC_GUARD = `ACC_GUARD;

  typedef logic [DATA_LEN-1:0] data_t;

endpackage

`default_nettype wire

// File: rtl/channel_accum_7_sat_shift.sv
// ============================================================================
// Module  : channel_accum_7_sat_shift
// Purpose : Combinational ACC_W -> OUT_W arithmetic right shift, signed
//           saturation and optional ReLU. Shared with the pooling stage.
// Ports   : i_acc  [ACC_W-1:0] signed accumulator value
//           o_data [OUT_W-1:0] shifted, saturated (and optionally clamped)
// Config  : RELU_EN defined -> negative saturated results forced to 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_accum_7_sat_shift #(
  parameter int ACC_W = 20,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic [ACC_W-1:0] i_acc,
  output logic [OUT_W-1:0] o_data
);

  localparam int HI_W = ACC_W - OUT_W + 1;

  logic signed [ACC_W-1:0] w_shifted;
  logic        [HI_W-1:0]  w_hi;
  logic                    w_ovf;
  logic        [OUT_W-1:0] w_sat;

  assign w_shifted = $signed(i_acc) >>> SHIFT;

  // The value fits in OUT_W bits only when every bit from the output sign
  // position upward is a copy of the accumulator sign.
  assign w_hi  = w_shifted[ACC_W-1:OUT_W-1];
  assign w_ovf = !((&w_hi) || (~|w_hi));

  assign w_sat = !w_ovf       ? w_shifted[OUT_W-1:0] :
                 w_hi[HI_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                {1'b0, {(OUT_W-1){1'b1}}};

`ifdef RELU_EN
  assign o_data = w_sat[OUT_W-1] ? '0 : w_sat;
`else
  assign o_data = w_sat;
`endif

endmodule

`default_nettype wire

// File: rtl/channel_accum_7.sv
// ============================================================================
// Module  : channel_accum_7
// Purpose : Accumulates NUM_PHASE partial sums from the dot-product channel,
//           adds the channel bias, shifts/saturates (optional ReLU) and
//           presents the result under a valid/ready handshake.
// Ports   : clk, rst (async, active-high)
//           in_valid, in_q   - channel partial (rising edge of in_valid = 1)
//           bias             - signed bias, taken on the first capture
//           abort            - flush the in-progress pixel
//           out_ready        - consumer accepts out_data
//           out_valid, out_data - held result
//           phase_cnt        - partials captured for current pixel
//           overrun          - sticky: result dropped while output pending
// Config  : RELU_EN defined -> negative results forced to 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_accum_7
  import channel_accum_7_pkg::*;
#(
  parameter int NUM_PHASE = 7,
  parameter int GUARD     = ACC_GUARD,
  parameter int SHIFT     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_LEN-1:0] in_q,
  input  logic [DATA_LEN-1:0] bias,
  input  logic                abort,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] out_data,
  output logic [2:0]          phase_cnt,
  output logic                overrun
);

  localparam int         ACC_W  = DATA_LEN + GUARD;
  localparam logic [2:0] c_LAST = 3'(NUM_PHASE - 1);

  logic             r_in_valid_d;
  logic [ACC_W-1:0] r_acc;
  logic [2:0]       r_phase;
  logic             r_out_valid;
  data_t            r_out_data;
  logic             r_overrun;

  logic             w_cap;
  logic             w_first;
  logic             w_last;
  logic             w_done;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_sum;
  data_t            w_res;

  // One capture per rising edge of in_valid, however long it stays high.
  assign w_cap   = in_valid & ~r_in_valid_d;
  assign w_first = (r_phase == 3'd0);
  assign w_last  = (r_phase == c_LAST);

  // The bias enters the sum as the base term of the first capture, so the
  // accumulator already holds it and no separate bias copy is needed.
  assign w_base = w_first ? {{GUARD{bias[DATA_LEN-1]}}, bias} : r_acc;
  assign w_sum  = w_base + {{GUARD{in_q[DATA_LEN-1]}}, in_q};

  // abort wins over a same-cycle capture, so it also suppresses completion.
  assign w_done = w_cap & ~abort & w_last;

  channel_accum_7_sat_shift #(
    .ACC_W (ACC_W),
    .OUT_W (DATA_LEN),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .i_acc  (w_sum),
    .o_data (w_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_valid_d <= 1'b0;
      r_acc        <= '0;
      r_phase      <= 3'd0;
    end else begin
      r_in_valid_d <= in_valid;
      if (abort) begin
        r_acc   <= '0;
        r_phase <= 3'd0;
      end else if (w_cap) begin
        if (w_last) begin
          r_acc   <= '0;
          r_phase <= 3'd0;
        end else begin
          r_acc   <= w_sum;
          r_phase <= r_phase + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_done) begin
        // A pending, unaccepted result is kept; the new one is dropped.
        if (r_out_valid && !out_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_res;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign phase_cnt = r_phase;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire
